// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/done handshake, signed mode and
// divide-by-zero detection. One quotient bit is resolved per clock.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic signed [WIDTH:0] trial;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_d        = zero_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    trial = signed'({rem_q, quo_q[WIDTH-1]}) - signed'({1'b0, div_q});

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d    = 1'b1;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = signed_mode & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
          neg_rem_d = signed_mode & dividend_in[WIDTH-1];
          if (divisor_in == '0) begin
            // The raw dividend rides in the quotient register to become the remainder.
            zero_d  = 1'b1;
            quo_d   = dividend_in;
            div_d   = '0;
            state_d = FINISH;
          end else begin
            zero_d  = 1'b0;
            quo_d   = magnitude(dividend_in, signed_mode);
            div_d   = magnitude(divisor_in, signed_mode);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (trial >= 0) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = FINISH;
      end
      FINISH: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
          quotient_d  = apply_sign(quo_q, neg_quo_q);
          remainder_d = apply_sign(rem_q, neg_rem_q);
        end
        div_by_zero_d = zero_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      zero_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      zero_q        <= zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider. Next generation of the PA1 divide datapath.
- Integrates the divisor holding register, the remainder/quotient shift register and the control FSM in one block.
- Adds a start/done handshake, signed mode and divide-by-zero detection.
- Used by the ALU/execute stage for DIV/REM-class operations.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (legal range 4..64)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk)
start  input  1  request a division; accepted only in IDLE
signed_mode  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend_in  input  WIDTH  dividend; sampled with start
divisor_in  input  WIDTH  divisor; sampled with start and held internally (inputs may change afterwards)
busy  output  1  high while an operation is in progress (RUN or FINISH)
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
quotient  output  WIDTH  result quotient; holds until the next done
remainder  output  WIDTH  result remainder; holds until the next done
div_by_zero  output  1  flag for the last result; updates together with done

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal registers cleared.
  - Reset takes priority over everything and aborts an operation in progress; no done is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - busy=0. If start==1 at edge k, capture operands and signed_mode.
  - Divisor nonzero: latch magnitudes (absolute values when signed_mode=1, raw values otherwise); clear partial remainder; iteration counter=0; go to RUN.
  - Divisor zero: go directly to FINISH with the zero flag set.
- RUN:
  - One restoring step per cycle: shift {rem,quo} left by 1; trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, quo[0]=1. Otherwise rem unchanged, quo[0]=0.
  - Counter increments each step. After exactly WIDTH steps (edges k+1..k+WIDTH) go to FINISH.
- FINISH, one cycle, at edge k+WIDTH+1:
  - Apply sign correction and register quotient, remainder and div_by_zero. Set done=1 for one cycle. Return to IDLE.
- Latency:
  - Normal division: start sampled at edge k gives done high in the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32).
  - Divide-by-zero: done high in the cycle after edge k+1.
- busy is 1 from the cycle after edge k until done is asserted; busy=0 in the done cycle.
- A new start is accepted in the done cycle, which gives back-to-back operation.
- Sign rules (signed_mode=1):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.
- Overflow (signed, most-negative / -1): quotient = most-negative value (wraps), remainder = 0, div_by_zero = 0. No trap.
- Divide-by-zero:
  - quotient = all ones, in both modes.
  - remainder = dividend_in as captured.
  - div_by_zero = 1.
- start while busy: ignored. The captured operands and the in-flight result are unaffected.
- Outputs change only at the FINISH edge or on reset.
- Counter width is $clog2(WIDTH+1).

Test Plan:
- WIDTH=32, unsigned, 100 / 7, start at edge k -> busy high for 33 cycles; done pulse one cycle after edge k+33; quotient=14, remainder=2, div_by_zero=0.
- Signed, -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7 / -2 -> quotient=-3, remainder=1.
- Divisor 0, dividend 0x1234 in both modes -> done one cycle after edge k+1; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. Next normal division clears div_by_zero.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0. Also unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Reset low at edge k+10 of a division -> at the next edge state=IDLE, busy=0, all outputs 0, no done. New start 50 / 5 afterwards -> quotient=10, remainder=0.
- start re-pulsed with different operands while busy, and inputs changed mid-operation -> result matches the first operands. WIDTH=8 instance: 255 / 16 -> quotient=15, remainder=15, done one cycle after edge k+9.
